// File: rtl/prefix_decoder_pkg.sv
// Shared constants and types for the 8086 prefix decoder front end.
package prefix_decoder_pkg;

   localparam logic [1:0] SEG_ES = 2'd0;
   localparam logic [1:0] SEG_CS = 2'd1;
   localparam logic [1:0] SEG_SS = 2'd2;
   localparam logic [1:0] SEG_DS = 2'd3;

   localparam logic [7:0] PFX_ES    = 8'h26;
   localparam logic [7:0] PFX_CS    = 8'h2E;
   localparam logic [7:0] PFX_SS    = 8'h36;
   localparam logic [7:0] PFX_DS    = 8'h3E;
   localparam logic [7:0] PFX_LOCK  = 8'hF0;
   localparam logic [7:0] PFX_REPNE = 8'hF2;
   localparam logic [7:0] PFX_REP   = 8'hF3;

   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_e;

endpackage

// File: rtl/prefix_decoder_classifier.sv
// Combinational classification of one instruction byte into 8086 prefix kinds.
module prefix_classifier
   import prefix_decoder_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic       is_prefix_o,
   output logic       is_seg_o,
   output logic [1:0] seg_o,
   output logic       is_lock_o,
   output logic       is_rep_o,
   output logic       is_repne_o
);

   always_comb begin
      is_prefix_o = 1'b0;
      is_seg_o    = 1'b0;
      seg_o       = SEG_ES;
      is_lock_o   = 1'b0;
      is_rep_o    = 1'b0;
      is_repne_o  = 1'b0;
      case (byte_i)
         PFX_ES:    begin is_prefix_o = 1'b1; is_seg_o = 1'b1; seg_o = SEG_ES; end
         PFX_CS:    begin is_prefix_o = 1'b1; is_seg_o = 1'b1; seg_o = SEG_CS; end
         PFX_SS:    begin is_prefix_o = 1'b1; is_seg_o = 1'b1; seg_o = SEG_SS; end
         PFX_DS:    begin is_prefix_o = 1'b1; is_seg_o = 1'b1; seg_o = SEG_DS; end
         PFX_LOCK:  begin is_prefix_o = 1'b1; is_lock_o  = 1'b1; end
         PFX_REPNE: begin is_prefix_o = 1'b1; is_repne_o = 1'b1; end
         PFX_REP:   begin is_prefix_o = 1'b1; is_rep_o   = 1'b1; end
         default:   begin is_prefix_o = 1'b0; end
      endcase
   end

endmodule

// File: rtl/prefix_decoder.sv
// Strips 8086 prefix bytes from the prefetch stream, accumulates per-instruction
// prefix state and presents the opcode byte to the sequencer.
module prefix_decoder
   import prefix_decoder_pkg::*;
#(
   parameter int MAX_PREFIX_COUNT = 15,
   parameter int COUNT_WIDTH      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   next_instruction,
   input  logic                   fifo_empty,
   input  logic [7:0]             fifo_rd_data,
   output logic                   fifo_rd_en,
   output logic [7:0]             opcode,
   output logic                   opcode_valid,
   input  logic                   opcode_ack,
   output logic                   segment_override,
   output logic [1:0]             override_sr,
   output logic                   override_active,
   output logic                   rep,
   output logic                   repne,
   output logic                   lock,
   output logic [COUNT_WIDTH-1:0] prefix_count
);

   state_e                 state_q, state_d;
   logic [7:0]             opcode_q, opcode_d;
   logic                   valid_q, valid_d;
   logic                   pulse_q, pulse_d;
   logic [1:0]             sr_q, sr_d;
   logic                   active_q, active_d;
   logic                   rep_q, rep_d;
   logic                   repne_q, repne_d;
   logic                   lock_q, lock_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   logic       pop;
   logic       cls_prefix, cls_seg, cls_lock, cls_rep, cls_repne;
   logic [1:0] cls_sr;

   prefix_classifier u_classifier (
      .byte_i      (fifo_rd_data),
      .is_prefix_o (cls_prefix),
      .is_seg_o    (cls_seg),
      .seg_o       (cls_sr),
      .is_lock_o   (cls_lock),
      .is_rep_o    (cls_rep),
      .is_repne_o  (cls_repne)
   );

   // next_instruction returns to FETCH in the same cycle, so the head byte can be taken at once.
   always_comb begin
      pop        = (!fifo_empty) && ((state_q == FETCH) || next_instruction);
      fifo_rd_en = pop;
   end

   always_comb begin
      state_d = state_q;
      if (next_instruction) begin
         state_d = FETCH;
      end else begin
         state_d = state_q;
      end
      if (pop && !cls_prefix) begin
         state_d = HOLD;
      end else begin
         state_d = state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Clear from next_instruction is applied before the popped byte is folded in.
   always_comb begin
      opcode_d = opcode_q;
      valid_d  = opcode_ack ? 1'b0 : valid_q;
      pulse_d  = 1'b0;
      sr_d     = sr_q;
      active_d = active_q;
      rep_d    = rep_q;
      repne_d  = repne_q;
      lock_d   = lock_q;
      count_d  = count_q;
      if (next_instruction) begin
         valid_d  = 1'b0;
         active_d = 1'b0;
         rep_d    = 1'b0;
         repne_d  = 1'b0;
         lock_d   = 1'b0;
         count_d  = {COUNT_WIDTH{1'b0}};
      end else begin
         count_d  = count_d;
      end
      if (pop && cls_prefix) begin
         if (cls_seg) begin
            sr_d     = cls_sr;
            pulse_d  = 1'b1;
            active_d = 1'b1;
         end
         if (cls_lock) begin
            lock_d = 1'b1;
         end
         if (cls_rep) begin
            rep_d   = 1'b1;
            repne_d = 1'b0;
         end
         if (cls_repne) begin
            rep_d   = 1'b0;
            repne_d = 1'b1;
         end
         if (count_d != COUNT_WIDTH'(MAX_PREFIX_COUNT)) begin
            count_d = count_d + COUNT_WIDTH'(1);
         end
      end else if (pop) begin
         opcode_d = fifo_rd_data;
         valid_d  = 1'b1;
      end else begin
         opcode_d = opcode_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q <= 8'h00;
         valid_q  <= 1'b0;
         pulse_q  <= 1'b0;
         sr_q     <= 2'd0;
         active_q <= 1'b0;
         rep_q    <= 1'b0;
         repne_q  <= 1'b0;
         lock_q   <= 1'b0;
         count_q  <= {COUNT_WIDTH{1'b0}};
      end else begin
         opcode_q <= opcode_d;
         valid_q  <= valid_d;
         pulse_q  <= pulse_d;
         sr_q     <= sr_d;
         active_q <= active_d;
         rep_q    <= rep_d;
         repne_q  <= repne_d;
         lock_q   <= lock_d;
         count_q  <= count_d;
      end
   end

   assign opcode           = opcode_q;
   assign opcode_valid     = valid_q;
   assign segment_override = pulse_q;
   assign override_sr      = sr_q;
   assign override_active  = active_q;
   assign rep              = rep_q;
   assign repne            = repne_q;
   assign lock             = lock_q;
   assign prefix_count     = count_q;

endmodule

// File: tb/tb_prefix_decoder.sv
// Directed and randomized bench for prefix_decoder against a prefix-list reference model.
module tb_prefix_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       next_instruction;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en;
   logic [7:0] opcode;
   logic       opcode_valid;
   logic       opcode_ack;
   logic       segment_override;
   logic [1:0] override_sr;
   logic       override_active;
   logic       rep;
   logic       repne;
   logic       lock;
   logic [3:0] prefix_count;

   int checks = 0;
   int errors = 0;

   // Reference model: the prefixes of the current instruction as a plain list.
   logic [7:0] m_pfx[$];
   logic [7:0] m_opcode;
   logic       m_valid, m_hold, m_pulse;
   logic [1:0] m_sr;
   logic [7:0] pfx_tab [7];

   prefix_decoder dut (
      .clk              (clk),
      .reset            (reset),
      .next_instruction (next_instruction),
      .fifo_empty       (fifo_empty),
      .fifo_rd_data     (fifo_rd_data),
      .fifo_rd_en       (fifo_rd_en),
      .opcode           (opcode),
      .opcode_valid     (opcode_valid),
      .opcode_ack       (opcode_ack),
      .segment_override (segment_override),
      .override_sr      (override_sr),
      .override_active  (override_active),
      .rep              (rep),
      .repne            (repne),
      .lock             (lock),
      .prefix_count     (prefix_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_pfx(input logic [7:0] b);
      bit r = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (pfx_tab[k] == b) r = 1'b1;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_pfx.delete();
      m_opcode = 8'h00;
      m_valid  = 1'b0;
      m_hold   = 1'b0;
      m_pulse  = 1'b0;
      m_sr     = 2'd0;
   endtask

   task automatic check_all(input string tag);
      logic       e_rep = 1'b0, e_repne = 1'b0, e_lock = 1'b0, e_act = 1'b0;
      logic [3:0] e_cnt;
      foreach (m_pfx[k]) begin
         if (m_pfx[k] == 8'hF3) begin e_rep = 1'b1; e_repne = 1'b0; end
         if (m_pfx[k] == 8'hF2) begin e_rep = 1'b0; e_repne = 1'b1; end
         if (m_pfx[k] == 8'hF0) e_lock = 1'b1;
         if (m_pfx[k] inside {8'h26, 8'h2E, 8'h36, 8'h3E}) e_act = 1'b1;
      end
      e_cnt = (m_pfx.size() > 15) ? 4'd15 : 4'(m_pfx.size());
      chk({tag, ".opcode"}, opcode, m_opcode);
      chk({tag, ".opcode_valid"}, {7'd0, opcode_valid}, {7'd0, m_valid});
      chk({tag, ".segment_override"}, {7'd0, segment_override}, {7'd0, m_pulse});
      chk({tag, ".override_sr"}, {6'd0, override_sr}, {6'd0, m_sr});
      chk({tag, ".override_active"}, {7'd0, override_active}, {7'd0, e_act});
      chk({tag, ".rep"}, {7'd0, rep}, {7'd0, e_rep});
      chk({tag, ".repne"}, {7'd0, repne}, {7'd0, e_repne});
      chk({tag, ".lock"}, {7'd0, lock}, {7'd0, e_lock});
      chk({tag, ".prefix_count"}, {4'd0, prefix_count}, {4'd0, e_cnt});
   endtask

   // Apply one cycle of inputs, check the pop strobe, advance the model and the clock, check outputs.
   task automatic cycle(input string tag, input bit nx, input bit emp, input logic [7:0] d, input bit ack);
      logic exp_rd;
      next_instruction = nx;
      fifo_empty       = emp;
      fifo_rd_data     = d;
      opcode_ack       = ack;
      #1;
      exp_rd = !emp && (!m_hold || nx);
      chk({tag, ".fifo_rd_en"}, {7'd0, fifo_rd_en}, {7'd0, exp_rd});
      m_pulse = 1'b0;
      if (ack) m_valid = 1'b0;
      if (nx) begin
         m_pfx.delete();
         m_valid = 1'b0;
         m_hold  = 1'b0;
      end
      if (exp_rd) begin
         if (is_pfx(d)) begin
            m_pfx.push_back(d);
            if (d inside {8'h26, 8'h2E, 8'h36, 8'h3E}) begin
               m_sr    = 2'((d - 8'h26) >> 3);
               m_pulse = 1'b1;
            end
         end else begin
            m_opcode = d;
            m_valid  = 1'b1;
            m_hold   = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
      next_instruction = 1'b0;
      opcode_ack       = 1'b0;
   endtask

   initial begin
      bit         nx, emp, ack;
      logic [7:0] d;
      pfx_tab = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'hF0, 8'hF2, 8'hF3};
      reset = 1'b1;
      next_instruction = 1'b0;
      fifo_empty = 1'b1;
      fifo_rd_data = 8'h00;
      opcode_ack = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all("reset");

      cycle("cs_pfx", 1'b0, 1'b0, 8'h2E, 1'b0);
      cycle("cs_op", 1'b0, 1'b0, 8'h8B, 1'b0);
      cycle("hold_nopop", 1'b0, 1'b0, 8'h26, 1'b0);
      cycle("hold_empty", 1'b0, 1'b1, 8'h00, 1'b0);

      cycle("clr1", 1'b1, 1'b1, 8'h00, 1'b0);
      cycle("es", 1'b0, 1'b0, 8'h26, 1'b0);
      cycle("ds", 1'b0, 1'b0, 8'h3E, 1'b0);
      cycle("stall", 1'b0, 1'b1, 8'h3E, 1'b0);
      cycle("rep", 1'b0, 1'b0, 8'hF3, 1'b0);
      cycle("movsb", 1'b0, 1'b0, 8'hA4, 1'b0);

      cycle("clr2", 1'b1, 1'b1, 8'h00, 1'b0);
      cycle("f2a", 1'b0, 1'b0, 8'hF2, 1'b0);
      cycle("f3a", 1'b0, 1'b0, 8'hF3, 1'b0);
      cycle("nop_a", 1'b0, 1'b0, 8'h90, 1'b0);
      cycle("clr3", 1'b1, 1'b1, 8'h00, 1'b0);
      cycle("f3b", 1'b0, 1'b0, 8'hF3, 1'b0);
      cycle("f2b", 1'b0, 1'b0, 8'hF2, 1'b0);
      cycle("nop_b", 1'b0, 1'b0, 8'h90, 1'b0);

      cycle("clr4", 1'b1, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 20; i++) cycle("lock_sat", 1'b0, 1'b0, 8'hF0, 1'b0);
      cycle("nop_sat", 1'b0, 1'b0, 8'h90, 1'b0);

      cycle("ack", 1'b0, 1'b1, 8'h00, 1'b1);
      cycle("next_ss", 1'b1, 1'b0, 8'h36, 1'b0);
      cycle("next_ack", 1'b0, 1'b0, 8'h55, 1'b0);
      cycle("both", 1'b1, 1'b0, 8'h40, 1'b1);

      cycle("clr5", 1'b1, 1'b1, 8'h00, 1'b0);
      cycle("mid_cs", 1'b0, 1'b0, 8'h2E, 1'b0);
      cycle("mid_lock", 1'b0, 1'b0, 8'hF0, 1'b0);
      #2;
      fifo_empty = 1'b1;
      reset = 1'b1;
      model_reset();
      #1;
      check_all("async_rst");
      chk("async_rst.fifo_rd_en", {7'd0, fifo_rd_en}, 8'd0);
      fifo_empty = 1'b0;
      #1;
      chk("async_rst.fetch", {7'd0, fifo_rd_en}, 8'd1);
      fifo_empty = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < 600; i++) begin
         nx  = m_hold ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 39) == 0);
         emp = ($urandom_range(0, 3) == 0);
         ack = ($urandom_range(0, 3) == 0);
         d   = ($urandom_range(0, 1) == 1) ? pfx_tab[$urandom_range(0, 6)] : 8'($urandom);
         cycle("rand", nx, emp, d, ack);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
